// File: rtl/conv_net_sequencer_if.sv
// Stream handshakes of the conv-net sequencer: the sample-accept side
// (in_v/in_ready) and the registered result side (out_d/out_v/out_ready).
interface conv_net_sequencer_if #(
  parameter int W    = 16,
  parameter int N_CH = 4
);
  logic              in_v;
  logic              in_ready;
  logic [N_CH*W-1:0] out_d;
  logic              out_v;
  logic              out_ready;

  // Environment side: offers samples and consumes results.
  modport master (
    output in_v,
    output out_ready,
    input  in_ready,
    input  out_d,
    input  out_v
  );

  // Sequencer side: accepts samples and presents results.
  modport slave (
    input  in_v,
    input  out_ready,
    output in_ready,
    output out_d,
    output out_v
  );
endinterface

// File: rtl/conv_net_sequencer.sv
// Control sequencer for a stack of dilated causal conv layers: shifts one
// input sample in, starts each layer in turn, strobes the activation cache
// between layers, and holds the final result under a valid/ready handshake.
// A per-layer watchdog traps stalled layers in a sticky ERROR state.
module conv_net_sequencer #(
  parameter int W        = 16,
  parameter int N_CH     = 4,
  parameter int N_LAYERS = 3,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  conv_net_sequencer_if.slave         io,
  output logic                        lsb_en,
  output logic [N_LAYERS-1:0]         conv_start,
  input  logic [N_LAYERS-1:0]         conv_done,
  output logic [N_LAYERS-2:0]         ac_en,
  input  logic [N_CH*W-1:0]           res_d,
  output logic                        busy,
  output logic                        err,
  output logic [$clog2(N_LAYERS)-1:0] cur_layer,
  output logic [CNT_W-1:0]            sample_cnt
);

  localparam int LW   = $clog2(N_LAYERS);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [LW-1:0]       LAST     = LW'(N_LAYERS - 1);
  localparam logic [WD_W-1:0]     WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [N_LAYERS-1:0] CS_ONE   = {{(N_LAYERS-1){1'b0}}, 1'b1};
  localparam logic [N_LAYERS-2:0] AC_ONE   = CS_ONE[N_LAYERS-2:0];

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_CACHE  = 3'd4,
    ST_OUTPUT = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       layer_q, layer_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                in_ready_q, in_ready_d;
  logic                lsb_en_q, lsb_en_d;
  logic [N_LAYERS-1:0] conv_start_q, conv_start_d;
  logic [N_LAYERS-2:0] ac_en_q, ac_en_d;
  logic [N_CH*W-1:0]   out_d_q, out_d_d;
  logic                out_v_q, out_v_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cur_done_s;
  logic [WD_W-1:0]     wd_inc_s;

  // Only the done bit of the layer currently being sequenced matters.
  assign cur_done_s = |(conv_done & (CS_ONE << layer_q));
  assign wd_inc_s   = wd_q + 1'b1;

  // Next-state and next-output logic; strobes are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    wd_d         = wd_q;
    in_ready_d   = 1'b0;
    lsb_en_d     = 1'b0;
    conv_start_d = '0;
    ac_en_d      = '0;
    out_d_d      = out_d_q;
    out_v_d      = out_v_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        layer_d = '0;
        if (io.in_v) begin
          state_d  = ST_SHIFT;
          lsb_en_d = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        layer_d      = '0;
        wd_d         = '0;
        conv_start_d = CS_ONE;
        state_d      = ST_START;
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cur_done_s) begin
          if (layer_q == LAST) begin
            out_d_d = res_d;
            out_v_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_OUTPUT;
          end else begin
            ac_en_d = AC_ONE << layer_q;
            state_d = ST_CACHE;
          end
        end else begin
          wd_d = wd_inc_s;
          if ((TIMEOUT != 0) && (wd_inc_s == WD_LIMIT)) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_CACHE: begin
        layer_d      = layer_q + 1'b1;
        wd_d         = '0;
        conv_start_d = CS_ONE << (layer_q + 1'b1);
        state_d      = ST_START;
      end
      ST_OUTPUT: begin
        if (io.out_ready) begin
          out_v_d    = 1'b0;
          in_ready_d = 1'b1;
          layer_d    = '0;
          state_d    = ST_IDLE;
        end else begin
          out_v_d = 1'b1;
        end
      end
      ST_ERROR: begin
        err_d   = 1'b1;
        out_v_d = 1'b0;
        state_d = ST_ERROR;
      end
      default: begin
        in_ready_d = 1'b1;
        layer_d    = '0;
        out_v_d    = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_ERROR);
  end

  // State and registered outputs; everything returns to idle on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      layer_q      <= '0;
      wd_q         <= '0;
      in_ready_q   <= 1'b1;
      lsb_en_q     <= 1'b0;
      conv_start_q <= '0;
      ac_en_q      <= '0;
      out_d_q      <= '0;
      out_v_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      wd_q         <= wd_d;
      in_ready_q   <= in_ready_d;
      lsb_en_q     <= lsb_en_d;
      conv_start_q <= conv_start_d;
      ac_en_q      <= ac_en_d;
      out_d_q      <= out_d_d;
      out_v_q      <= out_v_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_d     = out_d_q;
  assign io.out_v     = out_v_q;
  assign lsb_en       = lsb_en_q;
  assign conv_start   = conv_start_q;
  assign ac_en        = ac_en_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign cur_layer    = layer_q;
  assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_conv_net_sequencer.sv
// Directed bench for conv_net_sequencer (3 layers, TIMEOUT=8, CNT_W=2).
// Expected strobe schedules are derived from per-layer done delays; expected
// results are queued when a sample is launched and popped when out_v rises.
module tb_conv_net_sequencer;
  localparam int W        = 16;
  localparam int N_CH     = 4;
  localparam int N_LAYERS = 3;
  localparam int TIMEOUT  = 8;
  localparam int CNT_W    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsb_en;
  logic [2:0]  conv_start;
  logic [2:0]  conv_done;
  logic [1:0]  ac_en;
  logic [63:0] res_d;
  logic        busy;
  logic        err;
  logic [1:0]  cur_layer;
  logic [1:0]  sample_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] q_exp[$];
  int          exp_cnt = 0;
  logic [63:0] last_out = 64'h0;

  conv_net_sequencer_if #(.W(W), .N_CH(N_CH)) io ();

  conv_net_sequencer #(
    .W(W), .N_CH(N_CH), .N_LAYERS(N_LAYERS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .io(io.slave),
    .lsb_en(lsb_en), .conv_start(conv_start), .conv_done(conv_done),
    .ac_en(ac_en), .res_d(res_d), .busy(busy), .err(err),
    .cur_layer(cur_layer), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // {in_ready, busy, err, lsb_en, conv_start[2:0], ac_en[1:0], out_v, cur_layer[1:0]}
  function automatic logic [11:0] ctl_vec();
    return {io.in_ready, busy, err, lsb_en, conv_start, ac_en, io.out_v, cur_layer};
  endfunction

  // One full sample: dN = extra RUN wait cycles of layer N, hold = cycles
  // out_ready stays low, keep_in keeps in_v high, spur raises conv_done[2] during layer 0.
  task automatic run_sample(input int d0, input int d1, input int d2,
                            input int hold, input bit keep_in, input bit spur);
    int          s [3];
    int          re [3];
    int          ca [2];
    int          oc;
    int          lay;
    logic [63:0] r;
    logic [63:0] exp_d;
    logic [11:0] ev;
    r = {$urandom(), $urandom()};
    res_d = r;
    q_exp.push_back(r);
    exp_cnt = (exp_cnt + 1) % 4;
    exp_d = 64'h0;
    s[0]  = 2;          re[0] = s[0] + 1 + d0; ca[0] = re[0] + 1;
    s[1]  = re[0] + 2;  re[1] = s[1] + 1 + d1; ca[1] = re[1] + 1;
    s[2]  = re[1] + 2;  re[2] = s[2] + 1 + d2; oc    = re[2] + 1;
    io.in_v = 1'b1;
    io.out_ready = 1'b0;
    conv_done = spur ? 3'b100 : 3'b000;
    for (int c = 1; c <= oc; c++) begin
      tick();
      lay = int'(c >= s[1]) + int'(c >= s[2]);
      ev = {1'b0, 1'b1, 1'b0, (c == 1), (c == s[2]), (c == s[1]), (c == s[0]),
            (c == ca[1]), (c == ca[0]), (c == oc), 2'(lay)};
      chk($sformatf("ctl_c%0d", c), 64'(ctl_vec()), 64'(ev));
      if (c == oc) begin
        exp_d = q_exp.pop_front();
        chk("out_d", io.out_d, exp_d);
        chk("sample_cnt", 64'(sample_cnt), 64'(exp_cnt));
      end
      io.in_v = keep_in;
      conv_done[0] = (c >= re[0]);
      conv_done[1] = (c >= re[1]);
      conv_done[2] = (c >= re[2]) || (spur && (c < re[0]));
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_ctl", 64'({io.out_v, io.in_ready, lsb_en, busy, |conv_start, |ac_en}),
          64'(6'b100100));
      chk("hold_data", io.out_d, exp_d);
    end
    io.out_ready = 1'b1;
    tick();
    chk("release", 64'({io.out_v, io.in_ready, busy, cur_layer}), 64'(5'b01000));
    last_out = exp_d;
    io.out_ready = 1'b0;
    conv_done = 3'b000;
    io.in_v = keep_in;
  endtask

  initial begin
    rst = 1'b0;
    io.in_v = 1'b0;
    io.out_ready = 1'b0;
    conv_done = 3'b000;
    res_d = 64'h0;
    tick();
    tick();
    chk("reset_ctl", 64'(ctl_vec()), 64'(12'h800));
    chk("reset_out_d", io.out_d, 64'h0);
    chk("reset_cnt", 64'(sample_cnt), 64'h0);
    rst = 1'b1;
    tick();

    // Nominal sample, every layer done in its first RUN cycle.
    run_sample(0, 0, 0, 0, 1'b0, 1'b0);
    // Layer 1 done delayed by 5 cycles.
    run_sample(0, 5, 0, 0, 1'b0, 1'b0);
    // Output backpressure for 20 cycles with in_v held high.
    run_sample(0, 0, 0, 20, 1'b1, 1'b0);
    // Accepted right after release; spurious conv_done[2] during a slow layer 0.
    run_sample(4, 0, 0, 0, 1'b0, 1'b1);

    // conv_done pulses while idle must not start anything.
    for (int i = 0; i < 3; i++) begin
      conv_done = 3'b111;
      tick();
      chk("idle_spurious", 64'(ctl_vec()), 64'(12'h800));
      conv_done = 3'b000;
      tick();
      chk("idle_quiet", 64'(ctl_vec()), 64'(12'h800));
    end

    // Fifth sample wraps the 2-bit counter to 1.
    run_sample(0, 2, 1, 3, 1'b0, 1'b0);
    chk("cnt_wrap", 64'(sample_cnt), 64'h1);

    // Watchdog: layer 0 never completes.
    io.in_v = 1'b1;
    conv_done = 3'b000;
    for (int c = 1; c <= 10; c++) begin
      tick();
      io.in_v = 1'b0;
      chk($sformatf("wd_wait_c%0d", c), 64'({err, busy}), 64'(2'b01));
    end
    tick();
    chk("wd_error", 64'(ctl_vec()), 64'(12'h200));
    io.in_v = 1'b1;
    io.out_ready = 1'b1;
    conv_done = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("err_sticky", 64'(ctl_vec()), 64'(12'h200));
      chk("err_out_d", io.out_d, last_out);
    end
    #2 rst = 1'b0;
    #1;
    chk("err_clear", 64'(ctl_vec()), 64'(12'h800));
    io.in_v = 1'b0;
    io.out_ready = 1'b0;
    conv_done = 3'b000;
    tick();
    rst = 1'b1;
    tick();
    chk("post_err_idle", 64'(ctl_vec()), 64'(12'h800));

    // Asynchronous reset in the middle of layer 1's RUN.
    exp_cnt = 0;
    io.in_v = 1'b1;
    conv_done = 3'b001;
    for (int c = 1; c <= 7; c++) begin
      tick();
      io.in_v = 1'b0;
    end
    chk("midrun_layer", 64'({busy, cur_layer}), 64'(3'b101));
    #2 rst = 1'b0;
    #1;
    chk("midrun_ctl", 64'(ctl_vec()), 64'(12'h800));
    chk("midrun_out_d", io.out_d, 64'h0);
    chk("midrun_cnt", 64'(sample_cnt), 64'(exp_cnt));
    conv_done = 3'b000;
    tick();
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_net_sequencer.md
Name: conv_net_sequencer

Overview:
- Parametrised control sequencer for a stacked dilated causal conv network of N_LAYERS layers.
- Accepts one input sample per valid/ready handshake and pulses the left-shift-buffer enable.
- Runs each conv layer in turn. Between layers it strobes that layer's activation cache. After the last layer it registers the final N_CH-channel result and holds it under a valid/ready output handshake.
- Adds capabilities the previous fixed 3-layer sequencer lacked: variable layer count, backpressure on input and output, a per-layer watchdog, a sticky error flag and a sample counter.

Parameters:
W, 16, width of one activation element (signed).
N_CH, 4, channels in the final layer output.
N_LAYERS, 3, number of conv layers sequenced; must be >= 2.
TIMEOUT, 255, maximum cycles spent in RUN for one layer; 0 disables the watchdog.
CNT_W, 16, width of the completed-sample counter.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
in_v  in  1  new input sample present.
in_ready  out  1  sequencer can accept a sample.
lsb_en  out  1  one-cycle shift strobe to the left shift buffer.
conv_start  out  N_LAYERS  one-hot, one-cycle start/reset pulse to conv layer i.
conv_done  in  N_LAYERS  layer i output valid; level or pulse.
ac_en  out  N_LAYERS-1  one-cycle capture strobe to the activation cache after layer i.
res_d  in  N_CH*W  last-layer output; channel k is bits [k*W +: W].
out_d  out  N_CH*W  registered network output.
out_v  out  1  out_d valid.
out_ready  in  1  consumer accepts out_d.
busy  out  1  high in every state except IDLE and ERROR.
err  out  1  sticky watchdog error.
cur_layer  out  $clog2(N_LAYERS)  index of the layer being sequenced.
sample_cnt  out  CNT_W  completed outputs; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; layer=0; all outputs 0 except in_ready=1.
- All outputs are registered.
- States: IDLE, SHIFT, START, RUN, CACHE, OUTPUT, ERROR.
- IDLE: in_ready=1. On in_v=1 go to SHIFT; in_ready drops on the same edge.
- SHIFT: lsb_en=1 for this cycle only; layer=0; go to START.
- START: conv_start[layer]=1 for exactly one cycle; clear the watchdog counter; go to RUN.
- RUN: sample conv_done[layer] only; conv_done bits of other layers are ignored.
  - If done and layer<N_LAYERS-1, go to CACHE.
  - If done and layer=N_LAYERS-1: on that edge out_d<=res_d, out_v<=1, sample_cnt++; go to OUTPUT.
  - If not done: watchdog counter++. When the counter equals TIMEOUT (and TIMEOUT!=0), go to ERROR.
- CACHE: ac_en[layer]=1 for one cycle; layer++; go to START.
- OUTPUT: hold out_d and out_v stable. On out_ready=1, out_v<=0 and go to IDLE.
- ERROR: err=1; all strobes 0; in_ready=0; out_v=0; out_d holds its last value. Exit only via reset.
- conv_done seen in any state other than RUN is ignored.
- cur_layer equals the layer register; it reads 0 in IDLE and SHIFT.
- Latency: when every conv_done arrives in the first RUN cycle, out_v rises 3*N_LAYERS+1 cycles after the in_v accept edge (10 for N_LAYERS=3). Each extra RUN wait cycle adds 1.
- Throughput: no overlap between samples. The next sample can be accepted no earlier than the cycle after out_ready consumes the output.
- sample_cnt wraps from 2^CNT_W-1 to 0 without flag.
- res_d is sampled only on the final-layer done edge; it is not registered at any other time.

Test Plan:
- Reset, then in_v pulse with conv_done tied high (N_LAYERS=3) -> lsb_en at cycle 1; conv_start bits 0/1/2 at cycles 2/5/8; ac_en bits 0/1 at 4/7; out_v=1 at cycle 10 with out_d=res_d; sample_cnt=1.
- conv_done[1] delayed 5 cycles -> out_v at cycle 15; exactly one conv_start pulse per layer; cur_layer=1 throughout the layer-1 wait.
- out_ready held 0 for 20 cycles while in_v=1 -> out_d and out_v stable, in_ready=0, no lsb_en. out_ready=1 -> out_v drops and IDLE accepts the next sample.
- TIMEOUT=8, conv_done[0] never asserted -> err=1 after 8 RUN cycles; no further strobes; only rst=0 clears err to 0.
- Spurious conv_done[2]=1 during layer 0 and conv_done pulses in IDLE -> no state advance and no strobes.
- rst=0 asserted mid-RUN of layer 1 -> immediate IDLE with all outputs at reset values. CNT_W=2 run for 5 samples -> sample_cnt reads 1.
